// File: rtl/snn_image_sequencer_if.sv
// -----------------------------------------------------------------------------
// snn_image_sequencer_if
// Signal bundle between the host JTAG word registers, the image sequencer and
// the run_network instance.
//
//   iNEXT          host chunk strobe (level, rising edge = iDATA valid)
//   iFINISH        strobed chunk is the last one of the image
//   iDATA          chunk words, word i at [i*WORD_W +: WORD_W]
//   oIMAGE         packed image presented to the SNN
//   oSNN_START     one-cycle SNN start pulse
//   iSNN_DONE      SNN finished (level or pulse)
//   iSNN_OUT       SNN neuron outputs
//   oRESULT        latched classification result
//   oRESULT_VALID  result available
//   oBUSY          sequencer is starting or running the SNN
//   oERROR         sticky flags: [0] overflow, [1] strobe while busy, [2] timeout
//
// Modports: master = host / SNN side, slave = sequencer.
// -----------------------------------------------------------------------------
interface snn_image_sequencer_if #(
  parameter int WORDS_PER_CHUNK = 14,
  parameter int WORD_W          = 32,
  parameter int IMG_BITS        = 800,
  parameter int OUT_W           = 2
) ();

  logic                              iNEXT;
  logic                              iFINISH;
  logic [WORDS_PER_CHUNK*WORD_W-1:0] iDATA;
  logic [IMG_BITS-1:0]               oIMAGE;
  logic                              oSNN_START;
  logic                              iSNN_DONE;
  logic [OUT_W-1:0]                  iSNN_OUT;
  logic [OUT_W-1:0]                  oRESULT;
  logic                              oRESULT_VALID;
  logic                              oBUSY;
  logic [2:0]                        oERROR;

  modport master (
    output iNEXT, iFINISH, iDATA, iSNN_DONE, iSNN_OUT,
    input  oIMAGE, oSNN_START, oRESULT, oRESULT_VALID, oBUSY, oERROR
  );

  modport slave (
    input  iNEXT, iFINISH, iDATA, iSNN_DONE, iSNN_OUT,
    output oIMAGE, oSNN_START, oRESULT, oRESULT_VALID, oBUSY, oERROR
  );

endinterface

// File: rtl/snn_image_sequencer.sv
// -----------------------------------------------------------------------------
// snn_image_sequencer
// Moves one image from the host JTAG word registers into the spiking-network
// input buffer, starts the network and latches its classification result.
// Lives in the 120 MHz domain; iNEXT is already synchronous to iCLK.
//
// Ports:
//   iCLK     system clock
//   iRESETn  asynchronous active-low reset (synchronous release upstream)
//   bus      snn_image_sequencer_if.slave (host strobe/data, image, SNN
//            start/done/result, status and sticky error flags)
//
// Optional feature (compile-time macro SNN_SEQ_TIMEOUT_EN):
//   defined   - RUN is bounded by TIMEOUT_CYC cycles; expiry sets oERROR[2]
//   undefined - RUN waits for done indefinitely, oERROR[2] is tied to 0
// -----------------------------------------------------------------------------
module snn_image_sequencer #(
  parameter int WORDS_PER_CHUNK = 14,
  parameter int WORD_W          = 32,
  parameter int IMG_BITS        = 800,
  parameter int OUT_W           = 2
`ifdef SNN_SEQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC     = 65535
`endif
) (
  input  logic                  iCLK,
  input  logic                  iRESETn,
  snn_image_sequencer_if.slave  bus
);

  localparam int CHUNK_BITS = WORDS_PER_CHUNK * WORD_W;
  localparam int MAX_CHUNKS = (IMG_BITS + CHUNK_BITS - 1) / CHUNK_BITS;
  localparam int IDX_W      = (MAX_CHUNKS > 1) ? $clog2(MAX_CHUNKS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_RUN
  } state_t;

  state_t              r_state;
  logic [IDX_W-1:0]    r_idx;
  logic                r_next_q;
  logic [IMG_BITS-1:0] r_image;
  logic                r_start;
  logic                r_busy;
  logic [OUT_W-1:0]    r_result;
  logic                r_result_valid;
  logic [1:0]          r_err;          // [0] overflow, [1] strobe while busy

  logic                w_edge;
  logic                w_last_slot;
  logic [IMG_BITS-1:0] w_image_wr;
  logic                w_err_timeout;

  // iNEXT is a level; only its rising edge delivers a chunk.
  assign w_edge      = bus.iNEXT & ~r_next_q;
  // A non-final chunk in the last slot would leave no room for the final one.
  assign w_last_slot = (int'(r_idx) + 1 == MAX_CHUNKS);

  // Image with the current chunk merged at offset idx*CHUNK_BITS. Bits that
  // would land at or beyond IMG_BITS simply have no destination.
  // NOTE: every always_comb output gets a full default before any conditional
  // update, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_image_wr = r_image;
    for (int b = 0; b < IMG_BITS; b++) begin
      if (b / CHUNK_BITS == int'(r_idx)) begin
        w_image_wr[b] = bus.iDATA[b % CHUNK_BITS];
      end
    end
  end

`ifdef SNN_SEQ_TIMEOUT_EN
  logic [15:0] r_run_cnt;
  logic        r_err_timeout;
  logic        w_timeout;

  // Counter holds the number of RUN cycles already elapsed, so the cycle in
  // which it reads TIMEOUT_CYC-1 is the last one allowed.
  assign w_timeout     = (r_run_cnt == 16'(TIMEOUT_CYC - 1));
  assign w_err_timeout = r_err_timeout;
`else
  assign w_err_timeout = 1'b0;
`endif

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values and simulation order cannot change the result.
  // NOTE: the image buffer is a plain register (not a RAM) and is reset along
  // with everything else, so a partial image never survives a reset.
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      r_state        <= ST_IDLE;
      r_idx          <= '0;
      r_next_q       <= 1'b0;
      r_image        <= '0;
      r_start        <= 1'b0;
      r_busy         <= 1'b0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_err          <= '0;
`ifdef SNN_SEQ_TIMEOUT_EN
      r_run_cnt      <= '0;
      r_err_timeout  <= 1'b0;
`endif
    end else begin
      r_next_q <= bus.iNEXT;
      r_start  <= 1'b0;

      case (r_state)
        ST_IDLE, ST_LOAD: begin
          if (w_edge) begin
            if (!bus.iFINISH && w_last_slot) begin
              // Overflow: chunk dropped, sequencer rearms for a fresh image.
              r_err[0] <= 1'b1;
              r_idx    <= '0;
              r_state  <= ST_IDLE;
            end else begin
              r_image <= w_image_wr;
              if (r_state == ST_IDLE) begin
                // First accepted chunk of a new image clears old status.
                r_err          <= '0;
                r_result_valid <= 1'b0;
`ifdef SNN_SEQ_TIMEOUT_EN
                r_err_timeout  <= 1'b0;
`endif
              end
              if (bus.iFINISH) begin
                r_idx   <= '0;
                r_state <= ST_START;
                r_start <= 1'b1;
                r_busy  <= 1'b1;
              end else begin
                r_idx   <= r_idx + IDX_W'(1);
                r_state <= ST_LOAD;
              end
            end
          end
        end

        ST_START: begin
          if (w_edge) r_err[1] <= 1'b1;
          r_state <= ST_RUN;
`ifdef SNN_SEQ_TIMEOUT_EN
          r_run_cnt <= '0;
`endif
        end

        ST_RUN: begin
          if (w_edge) r_err[1] <= 1'b1;
          if (bus.iSNN_DONE) begin
            r_result       <= bus.iSNN_OUT;
            r_result_valid <= 1'b1;
            r_busy         <= 1'b0;
            r_state        <= ST_IDLE;
          end
`ifdef SNN_SEQ_TIMEOUT_EN
          else if (w_timeout) begin
            r_err_timeout <= 1'b1;
            r_busy        <= 1'b0;
            r_state       <= ST_IDLE;
          end else begin
            r_run_cnt <= r_run_cnt + 16'd1;
          end
`endif
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.oIMAGE        = r_image;
  assign bus.oSNN_START    = r_start;
  assign bus.oRESULT       = r_result;
  assign bus.oRESULT_VALID = r_result_valid;
  assign bus.oBUSY         = r_busy;
  assign bus.oERROR        = {w_err_timeout, r_err};

endmodule

// File: tb/tb_snn_image_sequencer.sv
// -----------------------------------------------------------------------------
// tb_snn_image_sequencer
// Self-checking bench for snn_image_sequencer. A behavioural model tracks the
// expected outputs from the image/chunk rules (chunk count, word positions,
// busy/start/result bookkeeping); a compare process checks every cycle, and
// directed scenarios pin literal values. Build with +define+SNN_SEQ_TIMEOUT_EN
// to exercise the RUN timeout (TIMEOUT_CYC = 100).
// -----------------------------------------------------------------------------
module tb_snn_image_sequencer;

  localparam int WPC        = 14;
  localparam int WORD_W     = 32;
  localparam int IMG_BITS   = 800;
  localparam int OUT_W      = 2;
  localparam int T_CYC      = 100;
  localparam int CHUNK_BITS = WPC * WORD_W;
  localparam int MAX_CHUNKS = (IMG_BITS + CHUNK_BITS - 1) / CHUNK_BITS;

  typedef logic [IMG_BITS-1:0]   vec_t;
  typedef logic [CHUNK_BITS-1:0] chunk_t;

  logic iCLK;
  logic iRESETn;

  snn_image_sequencer_if #(
    .WORDS_PER_CHUNK(WPC), .WORD_W(WORD_W), .IMG_BITS(IMG_BITS), .OUT_W(OUT_W)
  ) bus ();

  snn_image_sequencer #(
    .WORDS_PER_CHUNK(WPC), .WORD_W(WORD_W), .IMG_BITS(IMG_BITS), .OUT_W(OUT_W)
`ifdef SNN_SEQ_TIMEOUT_EN
    , .TIMEOUT_CYC(T_CYC)
`endif
  ) dut (
    .iCLK   (iCLK),
    .iRESETn(iRESETn),
    .bus    (bus)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input vec_t act, input vec_t exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  logic             m_next_q, m_edge, m_start, m_busy, m_valid;
  logic [OUT_W-1:0] m_result;
  logic [2:0]       m_err;
  vec_t             m_image;
  int               m_chunks;   // chunks already accepted for current image
  int               m_run;      // RUN cycles elapsed
  logic [WORD_W-1:0] m_word;
  int               m_pos;

  always @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      m_next_q = 0; m_start = 0; m_busy = 0; m_valid = 0;
      m_result = '0; m_err = '0; m_image = '0; m_chunks = 0; m_run = 0;
    end else begin
      m_edge   = bus.iNEXT && !m_next_q;
      m_next_q = bus.iNEXT;
      if (m_busy) begin
        if (m_edge) m_err[1] = 1'b1;
        if (m_start) begin
          m_start = 1'b0;
          m_run   = 0;
        end else if (bus.iSNN_DONE) begin
          m_result = bus.iSNN_OUT;
          m_valid  = 1'b1;
          m_busy   = 1'b0;
        end else begin
          m_run++;
`ifdef SNN_SEQ_TIMEOUT_EN
          if (m_run == T_CYC) begin
            m_err[2] = 1'b1;
            m_busy   = 1'b0;
          end
`endif
        end
      end else if (m_edge) begin
        if (!bus.iFINISH && m_chunks + 1 == MAX_CHUNKS) begin
          m_err[0] = 1'b1;
          m_chunks = 0;
        end else begin
          if (m_chunks == 0) begin
            m_err   = '0;
            m_valid = 1'b0;
          end
          for (int w = 0; w < WPC; w++) begin
            m_word = bus.iDATA[w*WORD_W +: WORD_W];
            for (int k = 0; k < WORD_W; k++) begin
              m_pos = m_chunks * CHUNK_BITS + w * WORD_W + k;
              if (m_pos < IMG_BITS) m_image[m_pos] = m_word[k];
            end
          end
          if (bus.iFINISH) begin
            m_chunks = 0;
            m_start  = 1'b1;
            m_busy   = 1'b1;
          end else begin
            m_chunks++;
          end
        end
      end
    end
  end

  // Every-cycle comparison, 2 time units after the active edge.
  logic cmp_en = 1'b0;
  always @(posedge iCLK) begin
    #2;
    if (cmp_en) begin
      check("cyc_image",  bus.oIMAGE,                m_image);
      check("cyc_start",  vec_t'(bus.oSNN_START),    vec_t'(m_start));
      check("cyc_busy",   vec_t'(bus.oBUSY),         vec_t'(m_busy));
      check("cyc_result", vec_t'(bus.oRESULT),       vec_t'(m_result));
      check("cyc_valid",  vec_t'(bus.oRESULT_VALID), vec_t'(m_valid));
      check("cyc_error",  vec_t'(bus.oERROR),        vec_t'(m_err));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change on the falling edge)
  // ---------------------------------------------------------------------------
  function automatic chunk_t mk_chunk(input logic [31:0] base);
    chunk_t c;
    for (int i = 0; i < WPC; i++) c[i*WORD_W +: WORD_W] = base + 32'(i);
    return c;
  endfunction

  function automatic chunk_t rnd_chunk();
    chunk_t c;
    for (int i = 0; i < WPC; i++) c[i*WORD_W +: WORD_W] = $urandom();
    return c;
  endfunction

  // Returns on the falling edge right after the strobe edge took effect.
  task automatic strobe(input chunk_t d, input logic fin, input int hold);
    @(negedge iCLK);
    bus.iDATA   = d;
    bus.iFINISH = fin;
    bus.iNEXT   = 1'b1;
    repeat (hold) @(negedge iCLK);
    bus.iNEXT   = 1'b0;
  endtask

  task automatic finish_run(input logic [OUT_W-1:0] out);
    @(negedge iCLK);
    bus.iSNN_OUT  = out;
    bus.iSNN_DONE = 1'b1;
    @(negedge iCLK);
    bus.iSNN_DONE = 1'b0;
  endtask

  function automatic vec_t ones_upper(input vec_t img, input chunk_t c);
    vec_t v = img;
    v[IMG_BITS-1:CHUNK_BITS] = c[IMG_BITS-CHUNK_BITS-1:0];
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    chunk_t d0, d1, x, y, z;
    vec_t   saved;
    int     busy_cnt;

    iRESETn       = 1'b0;
    bus.iNEXT     = 1'b0;
    bus.iFINISH   = 1'b0;
    bus.iDATA     = '0;
    bus.iSNN_DONE = 1'b0;
    bus.iSNN_OUT  = '0;
    repeat (3) @(negedge iCLK);
    check("rst_image", bus.oIMAGE, '0);
    check("rst_flags", vec_t'({bus.oSNN_START, bus.oBUSY, bus.oRESULT_VALID,
                               bus.oRESULT, bus.oERROR}), '0);
    iRESETn = 1'b1;
    cmp_en  = 1'b1;

    // Two-chunk load, start pulse, result latch
    strobe(mk_chunk(32'h0000_0000), 1'b0, 1);
    check("t1_start_before", vec_t'(bus.oSNN_START), vec_t'(1'b0));
    strobe(mk_chunk(32'hA5A5_0000), 1'b1, 1);
    check("t1_start_pulse", vec_t'(bus.oSNN_START), vec_t'(1'b1));
    check("t1_img_w0",   vec_t'(bus.oIMAGE[31:0]),    vec_t'(32'h0000_0000));
    check("t1_img_w1",   vec_t'(bus.oIMAGE[63:32]),   vec_t'(32'h0000_0001));
    check("t1_img_c1w0", vec_t'(bus.oIMAGE[479:448]), vec_t'(32'hA5A5_0000));
    check("t1_img_last", vec_t'(bus.oIMAGE[799:768]), vec_t'(32'hA5A5_000A));
    @(negedge iCLK);
    check("t1_start_end", vec_t'(bus.oSNN_START), vec_t'(1'b0));
    check("t1_busy_run",  vec_t'(bus.oBUSY),      vec_t'(1'b1));
    finish_run(2'b10);
    check("t2_result", vec_t'(bus.oRESULT),       vec_t'(2'b10));
    check("t2_valid",  vec_t'(bus.oRESULT_VALID), vec_t'(1'b1));
    check("t2_busy",   vec_t'(bus.oBUSY),         vec_t'(1'b0));

    // Long strobe counts once; strobe while busy is ignored and flagged
    d0 = rnd_chunk();
    d1 = rnd_chunk();
    strobe(d0, 1'b0, 10);
    check("t3_valid_clr", vec_t'(bus.oRESULT_VALID), vec_t'(1'b0));
    check("t3_chunk0", vec_t'(bus.oIMAGE[CHUNK_BITS-1:0]), vec_t'(d0));
    strobe(d1, 1'b1, 1);
    saved = ones_upper({{(IMG_BITS-CHUNK_BITS){1'b0}}, d0}, d1);
    check("t3_image", bus.oIMAGE, saved);
    check("t3_start", vec_t'(bus.oSNN_START), vec_t'(1'b1));
    strobe('1, 1'b0, 1);
    check("t4_image_held", bus.oIMAGE, saved);
    check("t4_err_busy",   vec_t'(bus.oERROR), vec_t'(3'b010));
    finish_run(2'b01);
    x = rnd_chunk();
    strobe(x, 1'b0, 1);
    check("t4_err_clr", vec_t'(bus.oERROR), vec_t'(3'b000));

    // Overflow: second non-final chunk dropped
    y = rnd_chunk();
    strobe(y, 1'b0, 1);
    check("t5_err_ovf", vec_t'(bus.oERROR), vec_t'(3'b001));
    check("t5_busy",    vec_t'(bus.oBUSY),  vec_t'(1'b0));
    check("t5_image", bus.oIMAGE, ones_upper({{(IMG_BITS-CHUNK_BITS){1'b0}}, x}, d1));
    z = rnd_chunk();
    strobe(z, 1'b1, 1);
    check("t5_single_start", vec_t'(bus.oSNN_START), vec_t'(1'b1));
    check("t5_single_chunk", vec_t'(bus.oIMAGE[CHUNK_BITS-1:0]), vec_t'(z));
    check("t5_err_clr", vec_t'(bus.oERROR), vec_t'(3'b000));
    finish_run(2'b11);

    // RUN without done
    strobe(rnd_chunk(), 1'b1, 1);
    busy_cnt = 1;
`ifdef SNN_SEQ_TIMEOUT_EN
    for (int i = 0; i < 300; i++) begin
      @(negedge iCLK);
      if (!bus.oBUSY) break;
      busy_cnt++;
    end
    check("t6_busy_cycles", vec_t'(busy_cnt),          vec_t'(T_CYC + 1));
    check("t6_err_tmo",     vec_t'(bus.oERROR),        vec_t'(3'b100));
    check("t6_valid",       vec_t'(bus.oRESULT_VALID), vec_t'(1'b0));
`else
    for (int i = 0; i < 200; i++) begin
      @(negedge iCLK);
      if (bus.oBUSY) busy_cnt++;
    end
    check("t6_busy_cycles", vec_t'(busy_cnt),   vec_t'(201));
    check("t6_err",         vec_t'(bus.oERROR), vec_t'(3'b000));
    finish_run(2'b11);
`endif

    // Reset mid-LOAD clears everything at once
    strobe(rnd_chunk(), 1'b0, 1);
    @(negedge iCLK);
    iRESETn = 1'b0;
    #1;
    check("t7_rst_image", bus.oIMAGE, '0);
    check("t7_rst_flags", vec_t'({bus.oSNN_START, bus.oBUSY, bus.oRESULT_VALID,
                                  bus.oRESULT, bus.oERROR}), '0);
    @(negedge iCLK);
    iRESETn = 1'b1;

    // Randomized images against the model
    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(negedge iCLK);
        bus.iSNN_OUT  = OUT_W'($urandom());
        bus.iSNN_DONE = 1'b1;
        @(negedge iCLK);
        bus.iSNN_DONE = 1'b0;
      end
      if ($urandom_range(0, 7) == 0) begin
        strobe(rnd_chunk(), 1'b0, $urandom_range(1, 3));
        strobe(rnd_chunk(), 1'b0, $urandom_range(1, 3));
      end else begin
        int n;
        n = $urandom_range(1, MAX_CHUNKS);
        for (int c = 0; c < n; c++) begin
          repeat ($urandom_range(0, 2)) @(negedge iCLK);
          strobe(rnd_chunk(), (c == n - 1), $urandom_range(1, 3));
        end
        repeat ($urandom_range(0, 12)) @(negedge iCLK);
        if ($urandom_range(0, 2) == 0) strobe(rnd_chunk(), 1'($urandom()), 1);
        @(negedge iCLK);
        bus.iSNN_OUT  = OUT_W'($urandom());
        bus.iSNN_DONE = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge iCLK);
        bus.iSNN_DONE = 1'b0;
      end
    end

    repeat (3) @(negedge iCLK);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
